// File: rtl/golden_pkg.sv
// Shared constants and types for the golden DFT reference datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package golden_pkg;

  localparam int GOLDEN_WIDTH       = 5;
  localparam int GOLDEN_DEPTH       = 2;
  localparam int GOLDEN_SYNC_STAGES = 2;

  typedef logic [GOLDEN_WIDTH-1:0] golden_word_t;

endpackage : golden_pkg

// File: rtl/golden_rst_sync.sv
// Active-low reset synchronizer: asserts asynchronously, releases synchronously to clk.
// Latency: rst_n_sync goes high on the SYNC_STAGES-th rising clk edge after rst_n rises.
// Backpressure: none.
//
// Ports:
//   clk        - clock the reset release is aligned to
//   rst_n      - raw asynchronous active-low reset
//   rst_n_sync - synchronized active-low reset (low as soon as rst_n is low)
module golden_rst_sync
  import golden_pkg::*;
#(
  parameter int SYNC_STAGES = GOLDEN_SYNC_STAGES  // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  // A constant 1 is shifted in; every flop clears the moment rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule : golden_rst_sync

// File: rtl/golden_design.sv
// Golden single-clock flop pipeline: data_in is carried bit-exact to data_out.
// Latency: DEPTH refclk edges (word sampled at edge N is on data_out after edge N+DEPTH-1).
// Backpressure: none; accepts one word per cycle unconditionally.
//
// Ports:
//   refclk   - only functional clock, rising edge
//   reset    - asynchronous active-low reset, synchronized internally before use
//   clk2     - legacy pin, terminated here; drives nothing
//   data_in  - WIDTH-bit input word
//   data_out - WIDTH-bit output word, taken straight from the last stage flop
module golden_design
  import golden_pkg::*;
#(
  parameter int WIDTH       = GOLDEN_WIDTH,
  parameter int DEPTH       = GOLDEN_DEPTH,        // legal range 1..8
  parameter int SYNC_STAGES = GOLDEN_SYNC_STAGES   // legal range 2..4
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             clk2,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic rst_n_sync;

  // clk2 only exists for pin compatibility; it ends on this dangling net so
  // the block stays a single clock domain.
  logic unused_clk2;
  assign unused_clk2 = clk2;

  golden_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk        (refclk),
    .rst_n      (reset),
    .rst_n_sync (rst_n_sync)
  );

  // Each stage owns its own register so no signal has more than one driver.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] q;

    if (k == 0) begin : g_first
      always_ff @(posedge refclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
          q <= '0;
        end else begin
          q <= data_in;
        end
      end
    end else begin : g_next
      always_ff @(posedge refclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
          q <= '0;
        end else begin
          q <= g_stage[k-1].q;
        end
      end
    end
  end

  assign data_out = g_stage[DEPTH-1].q;

endmodule : golden_design

// File: tb/tb_golden_design.sv
module tb_golden_design;
  import golden_pkg::*;

  logic refclk    = 1'b0;
  logic clk2_slow = 1'b0;
  logic reset     = 1'b0;
  golden_word_t data_in = '1;

  golden_word_t out_ph, out_c0, out_c1, out_sl, out_cx, out_d1, out_d4;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboards, one per pipeline depth; the DEPTH=2 one serves every clk2 variant.
  golden_word_t q1[$];
  golden_word_t q2[$];
  golden_word_t q4[$];

  always #5 refclk = ~refclk;
  always #7 clk2_slow = ~clk2_slow;

  golden_design #(.DEPTH(2)) u_ph (.refclk(refclk), .reset(reset), .clk2(refclk),    .data_in(data_in), .data_out(out_ph));
  golden_design #(.DEPTH(2)) u_c0 (.refclk(refclk), .reset(reset), .clk2(1'b0),      .data_in(data_in), .data_out(out_c0));
  golden_design #(.DEPTH(2)) u_c1 (.refclk(refclk), .reset(reset), .clk2(1'b1),      .data_in(data_in), .data_out(out_c1));
  golden_design #(.DEPTH(2)) u_sl (.refclk(refclk), .reset(reset), .clk2(clk2_slow), .data_in(data_in), .data_out(out_sl));
  golden_design #(.DEPTH(2)) u_cx (.refclk(refclk), .reset(reset), .clk2(1'bx),      .data_in(data_in), .data_out(out_cx));
  golden_design #(.DEPTH(1)) u_d1 (.refclk(refclk), .reset(reset), .clk2(refclk),    .data_in(data_in), .data_out(out_d1));
  golden_design #(.DEPTH(4)) u_d4 (.refclk(refclk), .reset(reset), .clk2(clk2_slow), .data_in(data_in), .data_out(out_d4));

  task automatic chk(input string tag, input golden_word_t got, input golden_word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input golden_word_t e1,
                         input golden_word_t e2, input golden_word_t e4);
    chk({tag, "/ph"}, out_ph, e2);
    chk({tag, "/c0"}, out_c0, e2);
    chk({tag, "/c1"}, out_c1, e2);
    chk({tag, "/sl"}, out_sl, e2);
    chk({tag, "/cx"}, out_cx, e2);
    chk({tag, "/d1"}, out_d1, e1);
    chk({tag, "/d4"}, out_d4, e4);
  endtask

  // Model contents of stages 0..DEPTH-2 after reset: all zero.
  task automatic clear_model();
    q1 = {};
    q2 = {};
    q4 = {};
    q2.push_back('0);
    for (int i = 0; i < 3; i++) q4.push_back('0);
  endtask

  // Drive one word for one edge. cap=0 means the pipeline is still held in
  // reset at this edge, so the model takes a zero instead of the word.
  task automatic step(input golden_word_t v, input bit cap, input string tag);
    golden_word_t m;
    golden_word_t e1, e2, e4;
    data_in = v;
    m = cap ? v : golden_word_t'(0);
    q1.push_back(m);
    q2.push_back(m);
    q4.push_back(m);
    @(posedge refclk);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    e4 = q4.pop_front();
    chk_all(tag, e1, e2, e4);
  endtask

  task automatic stream(input string tag);
    golden_word_t seq [5];
    seq[0] = 5'b00001;
    seq[1] = 5'b00100;
    seq[2] = 5'b00011;
    seq[3] = 5'b00111;
    seq[4] = 5'b11111;
    foreach (seq[i]) step(seq[i], 1'b1, tag);
  endtask

  initial begin
    clear_model();

    // Reset held low with all-ones input: outputs stay zero.
    for (int i = 0; i < 3; i++) step(5'b11111, 1'b0, "rst_hold");

    // Release between edges; the first two edges are synchronizer edges.
    #3 reset = 1'b1;
    step(5'b00001, 1'b0, "sync_e1");
    step(5'b00001, 1'b0, "sync_e2");
    step(5'b00001, 1'b1, "first_cap");
    step(5'b00001, 1'b1, "first_cap2");

    // Streaming and hold.
    stream("stream");
    for (int i = 0; i < 5; i++) step(5'b11111, 1'b1, "hold");

    // Mid-stream reset pulse, half a cycle long.
    step(5'b00111, 1'b1, "mid_a");
    step(5'b11111, 1'b1, "mid_b");
    reset = 1'b0;
    #1;
    chk_all("async_clr", '0, '0, '0);
    clear_model();
    #3 reset = 1'b1;
    step(5'b10101, 1'b0, "mid_sync1");
    step(5'b10101, 1'b0, "mid_sync2");
    stream("restream");
    for (int i = 0; i < 4; i++) step(5'b00000, 1'b1, "flush");

    // Random traffic.
    for (int i = 0; i < 20; i++) step(golden_word_t'($urandom_range(0, 31)), 1'b1, "rand");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule : tb_golden_design

// File: doc/golden_design.md
Name: golden_design

Overview:
- Single-clock, scan-friendly (DRC-clean) reference datapath used as the "golden" block for DFT rule checking.
- Registers a 5-bit input through a fixed-depth flop pipeline to a 5-bit output.
- Every flop is clocked by refclk and reset through one internally synchronized asynchronous reset. There is no derived clock, no gated clock and no combinational reset.
- Sits at the leaf of the DFT test hierarchy. It is the known-good baseline against which rule-violating variants are compared.

Parameters:
- WIDTH, 5, data path width in bits.
- DEPTH, 2, number of pipeline register stages between data_in and data_out (legal range 1..8).
- SYNC_STAGES, 2, flop count of the reset synchronizer (legal range 2..4).

Ports:
- refclk  input  1  sole functional clock; all flops update on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clk2  input  1  legacy pin kept for pin compatibility only. It must not clock any flop, must not feed any logic, and must be terminated internally. This keeps the block single-domain for DRC.
- data_in  input  WIDTH  input data word.
- data_out  output  WIDTH  registered output word.

Behaviour:
- Clocking: one clock, refclk, rising edge only. No negedge flops. No latches. No clock muxing or gating.
- Reset synchronizer:
  - SYNC_STAGES flops, all async-cleared by reset low; the first stage's D input is tied to 1.
  - The synchronizer output rst_n_sync asserts (goes low) immediately when reset goes low.
  - rst_n_sync deasserts on the SYNC_STAGES-th rising refclk edge after reset goes high.
- Pipeline:
  - DEPTH registers of WIDTH bits. Stage0 <= data_in; stage[k] <= stage[k-1]; data_out = last stage, driven directly from a flop with no output logic.
  - All pipeline flops are async-cleared by rst_n_sync low, to all-zero.
- Reset values: data_out = 0 and every internal flop = 0. This holds from the instant reset goes low, with no clock required.
- Latency: a value sampled on data_in at rising edge N appears on data_out after rising edge N+DEPTH-1, i.e. stable during the cycle following edge N+DEPTH-1. With DEPTH=2, data_out follows data_in by 2 edges.
- Throughput: one new word per cycle, no stall and no handshake.
- Data is passed unmodified, bit-exact and unsigned, with no arithmetic.
- After reset release: the pipeline captures data_in on the first edge at which rst_n_sync is high. Earlier edges hold zero.
- Reset mid-stream: reset low clears all stages and data_out asynchronously, and in-flight words are discarded. After release, data_out stays 0 until new data has traversed all DEPTH stages.
- clk2 toggling, static or X has no effect on any output.
- X on data_in propagates as X only through the affected pipeline slots.

Decomposition:
- Shared package golden_pkg:
  - GOLDEN_WIDTH = 5
  - GOLDEN_DEPTH = 2
  - GOLDEN_SYNC_STAGES = 2
  - typedef golden_word_t as logic [GOLDEN_WIDTH-1:0]
- One sub-module, golden_rst_sync: the asynchronous-assert / synchronous-deassert active-low reset synchronizer, parameterized by SYNC_STAGES.
- Pipeline stages are implemented in a generate loop in the top.

Test Plan:
- Reset: drive reset=0 with data_in=5'b11111 and clocks running for 3 cycles -> data_out=5'b00000 throughout. Then drive reset low asynchronously between edges -> data_out goes to 0 at once.
- Release latency: raise reset, then apply data_in=5'b00001 from the first cycle rst_n_sync is high -> data_out=5'b00001 exactly 2 edges later, and 0 before.
- Streaming: after release, apply 00001, 00100, 00011, 00111, 11111 on consecutive edges -> data_out shows the same sequence delayed 2 cycles, with no gaps or repeats. Hold 11111 -> data_out stays 11111.
- Mid-stream reset: while streaming 00111 then 11111, pulse reset low for half a cycle -> data_out=0 immediately. The first post-release word appears after SYNC_STAGES+DEPTH edges.
- clk2 independence: repeat the streaming test with clk2 toggling in phase, held 0, held 1, and at a different period -> data_out identical in all cases.
- Parameter sweep: DEPTH=1 and DEPTH=4 with the streaming sequence -> latency of 1 and 4 edges respectively, with values unchanged.
